// File: rtl/mem_req_sched.sv
// Request scheduler in front of the memory controller: queues host requests in a
// circular FIFO and issues them one at a time, returning in-order responses.
module mem_req_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rnw,
  input  logic [15:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   cmd_n,
  output logic                   RDnWR,
  output logic [15:0]            Addr_in,
  output logic [31:0]            Data_in,
  output logic                   Data_in_vld,
  input  logic [2:0]             ctrl_command,
  input  logic [31:0]            ctrl_data_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] CMD_ACT   = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;

  typedef struct packed {
    logic        rnw;
    logic [15:0] addr;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               cmd_n_q, cmd_n_d;
  logic               rdnwr_q, rdnwr_d;
  logic [15:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               dvld_q, dvld_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic               push_c;
  logic               pop_c;
  logic               timeout_c;
  logic [TMR_W-1:0]   timer_inc_c;
  entry_t             head_c;

  // FIFO handshake: a full FIFO refuses pushes even when a pop happens on the same edge
  assign req_ready   = (count_q < CNT_W'(DEPTH));
  assign push_c      = req_valid && req_ready;
  assign pop_c       = (state_q == S_RESP);
  assign head_c      = mem_q[rd_ptr_q];
  assign timeout_c   = (timer_q == TMR_W'(TIMEOUT));
  assign timer_inc_c = timeout_c ? timer_q : timer_q + TMR_W'(1);

  // Entry storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= '{rnw: req_rnw, addr: req_addr, wdata: req_wdata};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM: next state plus registered controller-side and response outputs
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cmd_n_d      = cmd_n_q;
    rdnwr_d      = rdnwr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    dvld_d       = dvld_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        cmd_n_d = 1'b1;
        if (count_q != '0) begin
          rdnwr_d = head_c.rnw;
          addr_d  = head_c.addr;
          data_d  = head_c.wdata;
          dvld_d  = !head_c.rnw;
          cmd_n_d = 1'b0;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end

      // Strobe held low until the controller activates, so it survives PRE/refresh cycles
      S_ISSUE: begin
        timer_d = timer_inc_c;
        cmd_n_d = 1'b0;
        if (timeout_c) begin
          cmd_n_d      = 1'b1;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else if (ctrl_command == CMD_ACT) begin
          cmd_n_d = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        timer_d = timer_inc_c;
        cmd_n_d = 1'b1;
        if (timeout_c) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          state_d      = S_RESP;
        end else if ((ctrl_command == CMD_READ) && rdnwr_q) begin
          state_d = S_CAPTURE;
        end else if ((ctrl_command == CMD_WRITE) && !rdnwr_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = S_RESP;
        end
      end

      S_CAPTURE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ctrl_data_out;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end

      S_RESP: begin
        dvld_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        cmd_n_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      cmd_n_q      <= 1'b1;
      rdnwr_q      <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      dvld_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      cmd_n_q      <= cmd_n_d;
      rdnwr_q      <= rdnwr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      dvld_q       <= dvld_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign fifo_count  = count_q;
  assign cmd_n       = cmd_n_q;
  assign RDnWR       = rdnwr_q;
  assign Addr_in     = addr_q;
  assign Data_in     = data_q;
  assign Data_in_vld = dvld_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_mem_req_sched.sv
// Bench for mem_req_sched: directed request table, FIFO-full and reset sequences,
// and randomized traffic against a reference memory and a behavioural controller.
module tb_mem_req_sched;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  localparam logic [2:0] C_NOP = 3'b000;
  localparam logic [2:0] C_ACT = 3'b001;
  localparam logic [2:0] C_RD  = 3'b010;
  localparam logic [2:0] C_WR  = 3'b011;
  localparam logic [2:0] C_PRE = 3'b100;
  localparam logic [2:0] C_REF = 3'b101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rnw = 1'b0;
  logic [15:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [CW-1:0] fifo_count;
  logic          cmd_n;
  logic          RDnWR;
  logic [15:0]   Addr_in;
  logic [31:0]   Data_in;
  logic          Data_in_vld;
  logic [2:0]    ctrl_command = 3'b000;
  logic [31:0]   ctrl_data_out = '0;

  always #5 clk = ~clk;

  mem_req_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .fifo_count(fifo_count), .cmd_n(cmd_n), .RDnWR(RDnWR), .Addr_in(Addr_in),
    .Data_in(Data_in), .Data_in_vld(Data_in_vld),
    .ctrl_command(ctrl_command), .ctrl_data_out(ctrl_data_out)
  );

  // One request plus controller behaviour and expected response
  typedef struct {
    bit          rnw;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          pre;
    int          gap;
    bit          hang;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          drain;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] cmem    [logic [15:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;
  bit push_pend = 0;
  bit pop_pend = 0;
  bit mon_en = 0;
  logic [31:0] last_rdata = '0;
  bit          last_err = 0;

  int          ph = 0;
  int          pre_left = 0;
  int          gap_left = 0;
  int          act_cyc = 0;
  int          rw_cyc = 0;
  bit          act_prev = 0;
  logic [31:0] rd_val = '0;
  req_t        cur;

  function automatic logic [31:0] fill(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  // Reference: requests complete strictly in order against a flat memory
  function automatic req_t ref_model(input req_t r);
    req_t o = r;
    if (r.hang) begin
      o.exp_rdata = '0;
      o.exp_err   = 1'b1;
    end else if (r.rnw) begin
      o.exp_rdata = ref_mem.exists(r.addr) ? ref_mem[r.addr] : fill(r.addr);
      o.exp_err   = 1'b0;
    end else begin
      ref_mem[r.addr] = r.wdata;
      o.exp_rdata = '0;
      o.exp_err   = 1'b0;
    end
    return o;
  endfunction

  function automatic req_t mk(input bit rnw, input logic [15:0] a, input logic [31:0] d,
                              input int pre, input int gap, input bit hang);
    req_t r;
    r.rnw = rnw; r.addr = a; r.wdata = d; r.pre = pre; r.gap = gap; r.hang = hang;
    r.exp_rdata = '0; r.exp_err = 1'b0; r.drain = 1'b0;
    return ref_model(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    req_t e;
    chk("fifo_count", 32'(fifo_count), 32'(model_cnt));
    chk("req_ready", 32'(req_ready), 32'(model_cnt < int'(DEPTH)));
    if (act_prev) chk("cmd_n_release", 32'(cmd_n), 32'd1);
    if (ph == 1) chk("cmd_n_hold", 32'(cmd_n), 32'd0);
    if ((ph == 1 || ph == 2 || ph == 4) && exp_q.size() > 0) begin
      chk("Addr_in", 32'(Addr_in), 32'(exp_q[0].addr));
      chk("Data_in", Data_in, exp_q[0].wdata);
      chk("RDnWR", 32'(RDnWR), 32'(exp_q[0].rnw));
      chk("Data_in_vld", 32'(Data_in_vld), 32'(!exp_q[0].rnw));
    end
    if (resp_valid) begin
      pop_pend = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp cyc=%0d got=resp_valid want=no response", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(e.exp_err));
        if (e.hang) chk("timeout_latency", 32'(cyc - act_cyc), 32'(TIMEOUT + 2));
        else        chk("resp_latency", 32'(cyc - rw_cyc), e.rnw ? 32'd2 : 32'd1);
        last_rdata = e.exp_rdata;
        last_err   = e.exp_err;
      end
    end else begin
      chk("rdata_hold", resp_rdata, last_rdata);
      chk("err_hold", 32'(resp_err), 32'(last_err));
    end
  endtask

  task automatic start_or_pre();
    if (pre_left > 0) begin
      ctrl_command = C_PRE;
      pre_left--;
      ph = 1;
    end else begin
      ctrl_command = C_ACT;
      act_cyc  = cyc;
      act_prev = 1'b1;
      gap_left = cur.gap;
      ph = 2;
    end
  endtask

  // Behavioural controller: PRE cycles, ACT, noise, then READ/WRITE (or silence)
  task automatic ctrl_step();
    act_prev = 1'b0;
    ctrl_data_out = $urandom();
    case (ph)
      0: begin
        ctrl_command = C_NOP;
        if (cmd_n == 1'b0 && exp_q.size() > 0) begin
          cur = exp_q[0];
          pre_left = cur.pre;
          start_or_pre();
        end
      end
      1: start_or_pre();
      2: begin
        if (gap_left > 0) begin
          gap_left--;
          case ($urandom_range(0, 4))
            0:       ctrl_command = C_NOP;
            1:       ctrl_command = C_REF;
            2:       ctrl_command = C_PRE;
            3:       ctrl_command = C_ACT;
            default: ctrl_command = RDnWR ? C_WR : C_RD;
          endcase
        end else if (cur.hang) begin
          ctrl_command = C_NOP;
          ph = 0;
        end else if (RDnWR) begin
          ctrl_command = C_RD;
          rw_cyc = cyc;
          rd_val = cmem.exists(Addr_in) ? cmem[Addr_in] : fill(Addr_in);
          ph = 4;
        end else begin
          ctrl_command = C_WR;
          rw_cyc = cyc;
          cmem[Addr_in] = Data_in;
          ph = 0;
        end
      end
      4: begin
        ctrl_command  = C_NOP;
        ctrl_data_out = rd_val;
        ph = 0;
      end
      default: ph = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (push_pend) model_cnt++;
    if (pop_pend)  model_cnt--;
    push_pend = 1'b0;
    pop_pend  = 1'b0;
    if (mon_en) monitor();
    ctrl_step();
  endtask

  task automatic send(input req_t r);
    int g = 0;
    req_valid = 1'b1;
    req_rnw   = r.rnw;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    while (model_cnt >= int'(DEPTH) && g < 600) begin
      tick();
      g++;
    end
    if (model_cnt >= int'(DEPTH)) begin
      checks++;
      errors++;
      $display("FAIL push_wait cyc=%0d got=fifo never drained want=space within 600 cycles", cyc);
    end else begin
      push_pend = 1'b1;
      exp_q.push_back(r);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || model_cnt != 0 || push_pend) && g < 600) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0 || model_cnt != 0) begin
      checks++;
      errors++;
      $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, exp_q.size());
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=still running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t tbl [6];
    req_t r;

    cmem[16'h1004] = 32'h1234_5678;

    // Reset held for three cycles with a request offered
    req_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_cmd_n", 32'(cmd_n), 32'd1);
    chk("rst_RDnWR", 32'(RDnWR), 32'd1);
    chk("rst_Addr_in", 32'(Addr_in), 32'd0);
    chk("rst_Data_in", Data_in, 32'd0);
    chk("rst_Data_in_vld", 32'(Data_in_vld), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // rnw, addr, wdata, pre, gap, hang, exp_rdata, exp_err, drain
    tbl[0] = '{1'b0, 16'h3A10, 32'hDEAD_BEEF, 0, 5, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 16'h1004, 32'h0000_0000, 0, 3, 1'b0, 32'h1234_5678, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h3A10, 32'h5555_AAAA, 8, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h0ABC, 32'h0000_0005, 0, 0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'h0ABC, 32'h0BAD_F00D, 2, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 16'h0ABC, 32'h0000_0000, 1, 4, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send(tbl[i]);
      if (tbl[i].drain) drain();
    end

    // Fill the FIFO behind a slow first request; the fifth waits for space
    for (int i = 0; i < 5; i++) begin
      r = mk((i % 2) == 1, 16'h2100 + 16'(i * 16), 32'h1000_0000 + 32'(i), (i == 0) ? 8 : 0, 1, 1'b0);
      send(r);
      if (i == 3) begin
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
      end
    end
    drain();

    // Randomized mixed traffic, often back-to-back so push and pop coincide
    for (int i = 0; i < 40; i++) begin
      r = mk(1'($urandom_range(0, 1)), 16'h2000 | (16'($urandom_range(0, 7)) << 4),
             $urandom(), $urandom_range(0, 3), $urandom_range(0, 4), i == 25);
      send(r);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    // Reset mid-operation discards queued and in-flight work
    send(mk(1'b1, 16'h2200, 32'h0, 6, 2, 1'b0));
    send(mk(1'b1, 16'h2210, 32'h0, 0, 1, 1'b0));
    send(mk(1'b1, 16'h2220, 32'h0, 0, 1, 1'b0));
    tick();
    chk("cmd_n_before_rst", 32'(cmd_n), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("cmd_n_async_rst", 32'(cmd_n), 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    model_cnt = 0; push_pend = 1'b0; pop_pend = 1'b0;
    ph = 0; act_prev = 1'b0; ctrl_command = C_NOP;
    last_rdata = '0; last_err = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_dvld", 32'(Data_in_vld), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
    send(mk(1'b0, 16'h2300, 32'h1357_9BDF, 0, 1, 1'b0));
    send(mk(1'b1, 16'h2300, 32'h0, 1, 0, 1'b0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_sched.md
# mem_req_sched

Request scheduler sitting directly upstream of the memory controller. Accepts host read/write requests over a valid/ready interface and buffers them in a circular FIFO. Issues one request at a time on the controller's cmd_n/RDnWR/Addr_in/Data_in inputs and tracks the controller's command output to detect completion. Returns one response per request (read data or write acknowledge), or a timeout error.

## Interface
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- TIMEOUT, 63, max cycles allowed in each wait state before aborting; ≥1.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  host request valid.
- req_ready  output  1  FIFO can accept; equals (count < DEPTH), combinational.
- req_rnw  input  1  1 = read, 0 = write.
- req_addr  input  16  {row[15:12], col[11:0]}.
- req_wdata  input  32  write data.
- resp_valid  output  1  one-cycle response pulse; no back-pressure.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  timeout flag, qualified by resp_valid.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- cmd_n  output  1  request strobe to controller, active-low.
- RDnWR  output  1  to controller, 1 = read.
- Addr_in  output  16  to controller.
- Data_in  output  32  to controller.
- Data_in_vld  output  1  high while a write is in flight.
- ctrl_command  input  3  controller command bus: NOP=000, ACT=001, READ=010, WRITE=011, PRE=100, REFRESH=101.
- ctrl_data_out  input  32  controller registered read data.

## Operation
- FIFO: entry is {rnw, addr, wdata}. Write pointer, read pointer, and count; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push occurs when req_valid && req_ready. Pop occurs on the RESP-state edge.
- Push and pop on the same edge leave count unchanged. When the FIFO is full, req_ready=0 and no push occurs, even if a pop happens on that edge.
- There is no bypass: a request always passes through the FIFO.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE: cmd_n=1. If count≠0, latch the head entry into the issue registers (RDnWR, Addr_in, Data_in, Data_in_vld=!rnw) and go to ISSUE.
- ISSUE: cmd_n=0, held until ctrl_command==ACT, then go to WAIT. Holding the strobe guarantees it is not missed while the controller cycles through PRE/IDLE.
- WAIT: cmd_n=1. On ctrl_command==READ with rnw=1, go to CAPTURE. On ctrl_command==WRITE with rnw=0, go to RESP with err=0. Any other command does not affect the FSM (REFRESH, PRE, and a mismatched READ/WRITE are ignored).
- CAPTURE: one cycle. Latch ctrl_data_out into the response data register, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, pop the FIFO, clear Data_in_vld, and return to IDLE.
- Timeout: a timer clears on entry to ISSUE and on entry to WAIT, and increments every cycle in those states. The timer is $clog2(TIMEOUT+1) bits and saturates. When timer==TIMEOUT, force cmd_n=1 and go to RESP with resp_err=1 and resp_rdata=0. The entry is still popped.
- The issue registers (RDnWR, Addr_in, Data_in) hold stable from IDLE exit until RESP exit.

## Timing
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, fifo_count=0, cmd_n=1, RDnWR=1, Addr_in=0, Data_in=0, Data_in_vld=0, FSM=IDLE, pointers and timer=0. req_ready=1 during and after reset.
- Reset asserted mid-operation discards all queued and in-flight requests and returns cmd_n to 1 immediately (asynchronous). No response is generated for discarded requests.
- A push at edge E0 into an empty idle FIFO gives cmd_n=0 from edge E1 onward.
- Read: READ seen on ctrl_command in cycle N → CAPTURE in cycle N+1 samples ctrl_data_out → resp_valid in cycle N+2.
- Write: WRITE seen in cycle N → resp_valid in cycle N+1.
- Timeout: resp_valid TIMEOUT+1 cycles after entry to the stalled state.
- Responses return strictly in request order. At most one request is outstanding at the controller.
- resp_rdata and resp_err keep their values after resp_valid falls, until the next response.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 → no push, fifo_count=0, cmd_n=1, req_ready=1, all outputs at reset values.
- Single write: addr 0x3A10, data 0xDEADBEEF; controller model responds ACT then WRITE 5 cycles later → Addr_in=0x3A10, Data_in=0xDEADBEEF, Data_in_vld=1 throughout; resp_valid one cycle after WRITE with err=0, rdata=0.
- Single read: addr 0x1004; model returns ctrl_data_out=0x12345678 one cycle after READ → resp_valid two cycles after READ, resp_rdata=0x12345678.
- FIFO full and wrap: push 5 requests back-to-back with DEPTH=4 → req_ready=0 after the 4th, fifo_count=4. Then run 10 mixed requests → responses arrive in order, pointers wrap correctly, and push with simultaneous pop keeps count constant.
- Missed strobe: model stays in PRE (command=100) for 8 cycles before ACT → cmd_n stays 0 for all 8 cycles and releases the cycle after ACT.
- Timeout: model never issues READ after ACT, TIMEOUT=63 → resp_valid 64 cycles after WAIT entry with err=1, rdata=0; the next queued request is issued afterwards.
